pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the core. It consumes the execute stage's jump_ena / jump_addr / hold_flag outputs and drives the PC redirect, the IF/ID and ID/EX flush, and the pipeline stall.
- It also launches and waits on a multi-cycle execution unit (mul/div) whenever the execute stage raises hold_flag.
- It sits between the execute stage and pc_reg / if_id / id_ex, and replaces the purely combinational jump forwarding.

---
 rtl/pipe_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller.
// Turns the execute stage's jump/hold requests into a registered PC redirect,
// a multi-cycle IF/ID + ID/EX flush, a stall while the mul/div unit runs, and
// a sticky timeout error. Optional performance counters are built only when
// PIPE_CTRL_PERF_EN is defined; otherwise the counter ports read 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | normal flow; accepts jump (priority) or multi-cycle hold
// FLUSH   | flush_o high; squashed-path jump/hold requests ignored
// MC_WAIT | stall_o high; waiting on mc_done_i or the timeout
// RELEASE | one unstalled cycle so the held op leaves EX; jumps honoured
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_ena_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             mc_done_i,
    output logic             pc_jump_ena_o,
    output logic [31:0]      pc_jump_addr_o,
    output logic             flush_o,
    output logic             stall_o,
    output logic             mc_start_o,
    output logic             err_o,
    output logic [CNT_W-1:0] jump_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    // Down-counters load N-1 and expire at 0, so N cycles are spent in-state.
    localparam logic [TO_W-1:0] TO_LOAD = (MC_TIMEOUT > 0) ? TO_W'(MC_TIMEOUT - 1) : '0;
    localparam logic [3:0]      FL_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_fl_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_pc_jump_ena;
    logic [31:0]       r_pc_jump_addr;
    logic              r_mc_start;
    logic              r_err;

    state_t            w_state_nxt;
    logic [3:0]        w_fl_cnt_nxt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic              w_take_jump;
    logic              w_launch;
    logic              w_err_set;
    logic              w_to_expired;

    // A zero MC_TIMEOUT means wait forever for mc_done_i.
    assign w_to_expired = (MC_TIMEOUT != 0) && (r_to_cnt == '0);

    // Next-state and transition strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_fl_cnt_nxt = r_fl_cnt;
        w_to_cnt_nxt = r_to_cnt;
        w_take_jump  = 1'b0;
        w_launch     = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (jump_ena_i) begin
                    w_take_jump  = 1'b1;
                    w_fl_cnt_nxt = FL_LOAD;
                    w_state_nxt  = FLUSH;
                end else if (hold_flag_i) begin
                    w_launch     = 1'b1;
                    w_to_cnt_nxt = TO_LOAD;
                    w_state_nxt  = MC_WAIT;
                end
            end
            FLUSH: begin
                if (r_fl_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_fl_cnt_nxt = r_fl_cnt - 4'd1;
                end
            end
            MC_WAIT: begin
                // A done arriving on the timeout cycle wins; no error then.
                if (mc_done_i) begin
                    w_state_nxt = RELEASE;
                end else if (w_to_expired) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (r_to_cnt != '0) begin
                    w_to_cnt_nxt = r_to_cnt - TO_W'(1);
                end
            end
            RELEASE: begin
                // hold_flag_i still belongs to the op that just finished.
                if (jump_ena_i) begin
                    w_take_jump  = 1'b1;
                    w_fl_cnt_nxt = FL_LOAD;
                    w_state_nxt  = FLUSH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_fl_cnt       <= '0;
            r_to_cnt       <= '0;
            r_pc_jump_ena  <= 1'b0;
            r_pc_jump_addr <= '0;
            r_mc_start     <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fl_cnt      <= w_fl_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_pc_jump_ena <= w_take_jump;
            r_mc_start    <= w_launch;
            if (w_take_jump) begin
                r_pc_jump_addr <= jump_addr_i;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc_jump_ena_o  = r_pc_jump_ena;
    assign pc_jump_addr_o = r_pc_jump_addr;
    assign mc_start_o     = r_mc_start;
    assign err_o          = r_err;
    assign flush_o        = (r_state == FLUSH);
    assign stall_o        = (r_state == MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_jump_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Free-running event counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_pc_jump_ena) begin
                r_jump_cnt <= r_jump_cnt + CNT_W'(1);
            end
            if (stall_o) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign jump_cnt_o  = r_jump_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign jump_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic. A
// cycle-level reference model pushes the expected outputs of every cycle into
// a queue; a separate monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

    localparam int unsigned FL = 2;
    localparam int unsigned TO = 6;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          jump_ena_i;
    logic [31:0]   jump_addr_i;
    logic          hold_flag_i;
    logic          mc_done_i;
    logic          pc_jump_ena_o;
    logic [31:0]   pc_jump_addr_o;
    logic          flush_o;
    logic          stall_o;
    logic          mc_start_o;
    logic          err_o;
    logic [CW-1:0] jump_cnt_o;
    logic [CW-1:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(FL), .MC_TIMEOUT(TO), .CNT_W(CW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .jump_ena_i     (jump_ena_i),
        .jump_addr_i    (jump_addr_i),
        .hold_flag_i    (hold_flag_i),
        .mc_done_i      (mc_done_i),
        .pc_jump_ena_o  (pc_jump_ena_o),
        .pc_jump_addr_o (pc_jump_addr_o),
        .flush_o        (flush_o),
        .stall_o        (stall_o),
        .mc_start_o     (mc_start_o),
        .err_o          (err_o),
        .jump_cnt_o     (jump_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    typedef struct packed {
        logic          pc;
        logic [31:0]   addr;
        logic          flush;
        logic          stall;
        logic          start;
        logic          err;
        logic [CW-1:0] jc;
        logic [CW-1:0] sc;
    } exp_t;

    exp_t q_exp[$];

    // Reference model: bookkeeping of remaining flush cycles and elapsed wait
    // cycles; each rising edge yields the outputs of the following cycle.
    initial begin
        exp_t cur;
        exp_t nx;
        int   flush_left;
        int   waited;
        bit   in_release;
        bit   nxt_release;
        cur        = '0;
        flush_left = 0;
        waited     = 0;
        in_release = 1'b0;
        forever begin
            @(posedge clk);
            nx          = cur;
            nx.pc       = 1'b0;
            nx.flush    = 1'b0;
            nx.stall    = 1'b0;
            nx.start    = 1'b0;
            nxt_release = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
            nx.jc = cur.jc + (cur.pc ? CW'(1) : CW'(0));
            nx.sc = cur.sc + (cur.stall ? CW'(1) : CW'(0));
`else
            nx.jc = '0;
            nx.sc = '0;
`endif
            if (rst) begin
                nx         = '0;
                flush_left = 0;
                waited     = 0;
            end else if (cur.flush) begin
                if (flush_left > 0) begin
                    nx.flush   = 1'b1;
                    flush_left = flush_left - 1;
                end
            end else if (cur.stall) begin
                waited = waited + 1;
                if (mc_done_i) begin
                    nxt_release = 1'b1;
                end else if (waited == TO) begin
                    nx.err      = 1'b1;
                    nxt_release = 1'b1;
                end else begin
                    nx.stall = 1'b1;
                end
            end else if (jump_ena_i) begin
                nx.pc      = 1'b1;
                nx.addr    = jump_addr_i;
                nx.flush   = 1'b1;
                flush_left = FL - 1;
            end else if (hold_flag_i && !in_release) begin
                nx.stall = 1'b1;
                nx.start = 1'b1;
                waited   = 0;
            end
            in_release = nxt_release;
            cur        = nx;
            q_exp.push_back(nx);
        end
    end

    // Monitor: compare every cycle's outputs against the model.
    initial begin
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                e   = q_exp.pop_front();
                cyc = cyc + 1;
                n_tests = n_tests + 1;
                if (pc_jump_ena_o !== e.pc || pc_jump_addr_o !== e.addr ||
                    flush_o !== e.flush || stall_o !== e.stall ||
                    mc_start_o !== e.start || err_o !== e.err ||
                    jump_cnt_o !== e.jc || stall_cnt_o !== e.sc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL outputs cycle %0d: got pc=%b addr=%h flush=%b stall=%b start=%b err=%b jc=%0d sc=%0d, want pc=%b addr=%h flush=%b stall=%b start=%b err=%b jc=%0d sc=%0d",
                             cyc, pc_jump_ena_o, pc_jump_addr_o, flush_o, stall_o,
                             mc_start_o, err_o, jump_cnt_o, stall_cnt_o,
                             e.pc, e.addr, e.flush, e.stall, e.start, e.err, e.jc, e.sc);
                end
            end
        end
    end

    task automatic chk(input string what, input logic ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: pc=%b addr=%h flush=%b stall=%b start=%b err=%b jc=%0d sc=%0d",
                     what, pc_jump_ena_o, pc_jump_addr_o, flush_o, stall_o,
                     mc_start_o, err_o, jump_cnt_o, stall_cnt_o);
        end
    endtask

    function automatic logic all_zero();
        return (pc_jump_ena_o === 1'b0) && (pc_jump_addr_o === 32'h0) &&
               (flush_o === 1'b0) && (stall_o === 1'b0) &&
               (mc_start_o === 1'b0) && (err_o === 1'b0) &&
               (jump_cnt_o === '0) && (stall_cnt_o === '0);
    endfunction

    task automatic step(input logic r, input logic j, input logic [31:0] a,
                        input logic h, input logic d);
        rst         = r;
        jump_ena_i  = j;
        jump_addr_i = a;
        hold_flag_i = h;
        mc_done_i   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with both requests high.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'hdead_beef, 1'b1, 1'b0);
            chk("reset state", all_zero());
        end
        idle(2);
        chk("post-reset idle", all_zero());

        // Taken jump, with a jump pulse two cycles later inside FLUSH.
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        idle(3);

        // Multi-cycle op, done on the 5th wait cycle, hold still high after.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(3);

        // Timeout with no done; err stays set afterwards.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("expired wait", (err_o === 1'b1) && (stall_o === 1'b0) && (mc_start_o === 1'b0));
        idle(3);
        chk("err sticky", err_o === 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(2);
        chk("err sticky after stray done", err_o === 1'b1);

        // Jump and hold together: jump wins.
        step(1'b0, 1'b1, 32'h0000_0404, 1'b1, 1'b0);
        idle(4);

        // Jump presented during RELEASE.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h1234_5679, 1'b1, 1'b0);
        idle(4);

        // Reset in the middle of a wait.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("mid-wait reset", (stall_o === 1'b0) && (mc_start_o === 1'b0) && (err_o === 1'b0));
        idle(3);

        // Three jumps and one 5-cycle stall from a clean reset.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 32'h0000_1000 + 32'(k), 1'b0, 1'b0);
            idle(3);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0));
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
